// File: rtl/gin_mcast_bus.sv
`default_nettype none
// ============================================================================
//  Module      : gin_mcast_bus
//  Description : Tag-matched multicast bus. A single source fans out to
//                NUM_TARGETS consumers, each with a scan-loaded ID. The bus
//                stays busy until every matched target has taken the word.
//                Words that match no target are dropped and counted.
//                Optional feature macro: GIN_BROADCAST_EN (all-ones tag
//                reaches every target).
//  Revision    : 1.0 - initial release
// ============================================================================
module gin_mcast_bus #(
    parameter int BITWIDTH    = 16,
    parameter int TAG_LENGTH  = 4,
    parameter int NUM_TARGETS = 10,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   program_en,
    input  logic [TAG_LENGTH-1:0]  scan_tag_in,
    output logic [TAG_LENGTH-1:0]  scan_tag_out,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [TAG_LENGTH-1:0]  src_tag,
    input  logic [BITWIDTH-1:0]    src_data,
    output logic [NUM_TARGETS-1:0] tgt_valid,
    input  logic [NUM_TARGETS-1:0] tgt_ready,
    output logic [BITWIDTH-1:0]    tgt_data,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    localparam logic [0:0]             c_IDLE = 1'b0;
    localparam logic [0:0]             c_BUSY = 1'b1;
    localparam logic [COUNT_WIDTH-1:0] c_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [TAG_LENGTH-1:0]  r_ids [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] r_pending;
    logic [NUM_TARGETS-1:0] w_pending_next;
    logic [NUM_TARGETS-1:0] w_match;
    logic [BITWIDTH-1:0]    r_data;
    logic [COUNT_WIDTH-1:0] r_drop_count;
    logic                   w_accept;
    logic                   w_shift;
    logic                   w_bcast;

    // Ready depends only on state and the program input, never on src_valid
    assign src_ready    = (r_state == c_IDLE) && !program_en && !rst;
    assign w_accept     = src_valid && src_ready;
    assign w_shift      = (r_state == c_IDLE) && program_en;
    assign scan_tag_out = r_ids[NUM_TARGETS-1];
    assign tgt_valid    = r_pending;
    assign tgt_data     = r_data;
    assign drop_count   = r_drop_count;

`ifdef GIN_BROADCAST_EN
    assign w_bcast = &src_tag;
`else
    assign w_bcast = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_match
            assign w_match[gi] = (r_ids[gi] == src_tag) || w_bcast;
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        case (r_state)
            c_IDLE: begin
                if (w_accept && (|w_match)) begin
                    w_state_next   = c_BUSY;
                    w_pending_next = w_match;
                end
            end
            c_BUSY: begin
                w_pending_next = r_pending & ~tgt_ready;
                if (w_pending_next == '0) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next   = c_IDLE;
                w_pending_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    // ID scan chain: target 0 is the chain input, the last target feeds the next bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                r_ids[i] <= '0;
            end
        end else if (w_shift) begin
            r_ids[0] <= scan_tag_in;
            for (int i = 1; i < NUM_TARGETS; i++) begin
                r_ids[i] <= r_ids[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_drop_count <= '0;
        end else if (w_accept) begin
            if (|w_match) begin
                r_data <= src_data;
            end else if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gin_mcast_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gin_mcast_bus
//  Description : Scoreboard bench for gin_mcast_bus with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gin_mcast_bus;
    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        program_en = 1'b0;
    logic [3:0]  scan_tag_in = '0;
    logic [3:0]  scan_tag_out;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [3:0]  src_tag = '0;
    logic [15:0] src_data = '0;
    logic [3:0]  tgt_valid;
    logic [3:0]  tgt_ready = '0;
    logic [15:0] tgt_data;
    logic [7:0]  drop_count;

    gin_mcast_bus #(
        .BITWIDTH(16), .TAG_LENGTH(4), .NUM_TARGETS(NT), .COUNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .program_en(program_en),
        .scan_tag_in(scan_tag_in), .scan_tag_out(scan_tag_out),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: IDs, per-target queues of words still owed, drop tally
    logic [3:0]  m_ids [NT];
    logic [15:0] exp_q [NT][$];
    int          m_drop = 0;
    logic        acc_d = 1'b0;
    logic        shift_d = 1'b0;
    logic [3:0]  acc_tag = '0;
    logic [3:0]  scan_d = '0;
    logic [15:0] acc_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_match(input logic [3:0] tag);
        logic [3:0] r;
        for (int i = 0; i < NT; i++) r[i] = (m_ids[i] == tag);
`ifdef GIN_BROADCAST_EN
        if (tag == 4'hF) r = 4'hF;
`endif
        return r;
    endfunction

    function automatic logic model_idle();
        logic idle;
        idle = 1'b1;
        for (int i = 0; i < NT; i++) if (exp_q[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    // One bus cycle: commit last cycle's predicted effects, check, drive new inputs
    task automatic cycle(input logic prog, input logic [3:0] scan, input logic sv,
                         input logic [3:0] tag, input logic [15:0] data, input logic [3:0] rdy);
        logic [3:0] m;
        logic       idle;
        @(posedge clk); #1;
        if (acc_d) begin
            m = model_match(acc_tag);
            if (m == 4'h0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                for (int i = 0; i < NT; i++) if (m[i]) exp_q[i].push_back(acc_data);
            end
        end
        if (shift_d) begin
            for (int i = NT-1; i > 0; i--) m_ids[i] = m_ids[i-1];
            m_ids[0] = scan_d;
        end
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("scan_tag_out", 32'(scan_tag_out), 32'(m_ids[NT-1]));
        program_en  = prog;
        scan_tag_in = scan;
        src_valid   = sv;
        src_tag     = tag;
        src_data    = data;
        tgt_ready   = rdy;
        idle = model_idle();
        #1;
        chk("src_ready", 32'(src_ready), 32'(idle && !prog));
        acc_d    = sv && idle && !prog;
        shift_d  = prog && idle;
        acc_tag  = tag;
        acc_data = data;
        scan_d   = scan;
    endtask

    // Monitor: mid-cycle, every presented valid must be owed a word; handshakes pop
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NT; i++) begin
                chk($sformatf("tgt_valid[%0d]", i), 32'(tgt_valid[i]), 32'(exp_q[i].size() != 0));
                if (tgt_valid[i] && tgt_ready[i] && exp_q[i].size() != 0) begin
                    chk($sformatf("tgt_data[%0d]", i), 32'(tgt_data), 32'(exp_q[i][0]));
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    function automatic logic [3:0] pick_tag();
        logic [3:0] t;
        case ($urandom_range(0, 5))
            0: t = 4'h0; 1: t = 4'h1; 2: t = 4'h2; 3: t = 4'h3; 4: t = 4'hF;
            default: t = 4'h7;
        endcase
        return t;
    endfunction

    initial begin
        logic [3:0] prog_seq [4];
        prog_seq[0] = 4'h3; prog_seq[1] = 4'h1; prog_seq[2] = 4'h2; prog_seq[3] = 4'h1;
        for (int i = 0; i < NT; i++) m_ids[i] = '0;
        #1;
        chk("reset tgt_valid", 32'(tgt_valid), 32'h0);
        chk("reset src_ready", 32'(src_ready), 32'h0);
        chk("reset tgt_data", 32'(tgt_data), 32'h0);
        #20 rst = 1'b0;

        // Program ids[0..3] = 1,2,1,3
        for (int i = 0; i < 4; i++) cycle(1'b1, prog_seq[i], 1'b0, 4'h0, 16'h0, 4'h0);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        chk("programmed tail id", 32'(scan_tag_out), 32'h3);

        // Multicast to targets 0 and 2 with all ready
        cycle(1'b0, 4'h0, 1'b1, 4'h1, 16'hABCD, 4'hF);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);

        // Staggered readiness
        cycle(1'b0, 4'h0, 1'b1, 4'h1, 16'h1357, 4'h0);
        cycle(1'b0, 4'h0, 1'b1, 4'h2, 16'hDEAD, 4'b0001);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'h0);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'b0100);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'h0);

        // All-ones tag
        cycle(1'b0, 4'h0, 1'b1, 4'hF, 16'hF00D, 4'hF);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);

        // Randomized traffic, occasional reprogramming (and program during BUSY)
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 9) == 0), pick_tag(), ($urandom_range(0, 3) != 0),
                  pick_tag(), 16'($urandom()), 4'($urandom()));
        end
        for (int n = 0; n < 4; n++) cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);

        // Reprogram 1,2,1,3 then flood with unmatched tag 7 until saturation
        for (int i = 0; i < 4; i++) cycle(1'b1, prog_seq[i], 1'b0, 4'h0, 16'h0, 4'h0);
        for (int n = 0; n < 300; n++) cycle(1'b0, 4'h0, 1'b1, 4'h7, 16'(n), 4'hF);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        chk("drop_count saturated", 32'(drop_count), 32'hFF);

        // Reset while target 2 is still pending
        cycle(1'b0, 4'h0, 1'b1, 4'h1, 16'h5A5A, 4'h0);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'b0001);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'h0);
        chk("pending before reset", 32'(tgt_valid), 32'b0100);
        rst = 1'b1;
        for (int i = 0; i < NT; i++) begin
            exp_q[i].delete();
            m_ids[i] = '0;
        end
        m_drop = 0;
        acc_d = 1'b0;
        shift_d = 1'b0;
        #1;
        chk("rst tgt_valid", 32'(tgt_valid), 32'h0);
        chk("rst drop_count", 32'(drop_count), 32'h0);
        chk("rst scan_tag_out", 32'(scan_tag_out), 32'h0);
        chk("rst src_ready", 32'(src_ready), 32'h0);
        @(posedge clk); #2 rst = 1'b0;

        // Tag 0 reaches every target with cleared IDs
        cycle(1'b0, 4'h0, 1'b1, 4'h0, 16'h1234, 4'h0);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        chk("post-reset broadcast", 32'(tgt_valid), 32'hF);
        for (int n = 0; n < 3; n++) cycle(1'b0, 4'h0, 1'b0, 4'h0, 16'h0, 4'hF);
        chk("scoreboard drained", 32'(model_idle()), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
